// File: rtl/game_ctrl.sv
// game_ctrl: breakout game-flow FSM (START/PLAY/WIN/END) with key synchronizer, hold timer and optional lives (macro LIVES_EN).
// Ports: vga_clk clock; sys_rst sync active-high reset; key_start raw async button; frame_tick per-frame pulse;
//        win_sig bricks cleared; ball_lost miss pulse; game_state 00 START/01 PLAY/10 WIN/11 END;
//        game_reset field reload pulse; serve re-serve pulse; lives remaining lives.
module game_ctrl #(
  parameter int HOLD_FRAMES = 60,
  parameter int LIVES_INIT = 3
) (
  input  logic       vga_clk,
  input  logic       sys_rst,
  input  logic       key_start,
  input  logic       frame_tick,
  input  logic       win_sig,
  input  logic       ball_lost,
  output logic [1:0] game_state,
  output logic       game_reset,
  output logic       serve,
  output logic [1:0] lives
);
  typedef enum logic [1:0] {START = 2'b00, PLAY = 2'b01, WIN = 2'b10, OVER = 2'b11} state_t;
`ifdef LIVES_EN
  localparam logic [1:0] LIVES_RST = 2'(LIVES_INIT);
`else
  localparam logic [1:0] LIVES_RST = 2'(LIVES_INIT >= 1);
`endif
  localparam logic [7:0] HOLD_MAX = 8'(HOLD_FRAMES);
  state_t state, state_n;
  logic [7:0] hold, hold_n;
  logic [1:0] lives_n;
  logic game_reset_n, serve_n;
  logic sync0, sync1, sync2, key_rise;
  logic hold_done;
  assign game_state = state;
  assign hold_done = hold == HOLD_MAX;
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      key_rise <= 1'b0;
      state <= START;
      hold <= 8'd0;
      lives <= LIVES_RST;
      game_reset <= 1'b0;
      serve <= 1'b0;
    end else begin
      sync0 <= key_start;
      sync1 <= sync0;
      sync2 <= sync1;
      key_rise <= sync1 & ~sync2;
      state <= state_n;
      hold <= hold_n;
      lives <= lives_n;
      game_reset <= game_reset_n;
      serve <= serve_n;
    end
  end
  always_comb begin
    state_n = state;
    hold_n = 8'd0;
    lives_n = lives;
    game_reset_n = 1'b0;
    serve_n = 1'b0;
    case (state)
      START: begin
        if (key_rise) begin
          state_n = PLAY;
          game_reset_n = 1'b1;
          serve_n = 1'b1;
          lives_n = LIVES_RST;
        end
      end
      PLAY: begin
        if (win_sig) begin
          state_n = WIN;
        end else if (ball_lost) begin
`ifdef LIVES_EN
          if (lives > 2'd1) begin
            lives_n = lives - 2'd1;
            serve_n = 1'b1;
          end else begin
            state_n = OVER;
            lives_n = 2'd0;
          end
`else
          state_n = OVER;
          lives_n = 2'd0;
`endif
        end
      end
      default: begin
        hold_n = (frame_tick && !hold_done) ? hold + 8'd1 : hold;
        if (key_rise && hold_done) begin
          state_n = START;
          hold_n = 8'd0;
`ifndef LIVES_EN
          lives_n = LIVES_RST;
`endif
        end
      end
    endcase
  end
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed self-checking bench for game_ctrl with HOLD_FRAMES=4, LIVES_INIT=3.
module tb_game_ctrl;
`ifdef LIVES_EN
  localparam logic [7:0] L0 = 8'd3;
`else
  localparam logic [7:0] L0 = 8'd1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_start = 1'b0;
  logic frame_tick = 1'b0;
  logic win_sig = 1'b0;
  logic ball_lost = 1'b0;
  logic [1:0] game_state;
  logic game_reset, serve;
  logic [1:0] lives;
  int total = 0;
  int bad = 0;
  int pulses_r, pulses_s;
  game_ctrl #(.HOLD_FRAMES(4), .LIVES_INIT(3)) dut (
    .vga_clk(clk), .sys_rst(rst), .key_start(key_start), .frame_tick(frame_tick),
    .win_sig(win_sig), .ball_lost(ball_lost), .game_state(game_state),
    .game_reset(game_reset), .serve(serve), .lives(lives)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic press();
    key_start = 1'b1;
    repeat (4) step();
  endtask
  task automatic release_key();
    key_start = 1'b0;
    repeat (3) step();
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask
  initial begin
    repeat (2) step();
    rst = 1'b0;
    chk("rst_state", 8'(game_state), 8'd0);
    chk("rst_greset", 8'(game_reset), 8'd0);
    chk("rst_serve", 8'(serve), 8'd0);
    chk("rst_lives", 8'(lives), L0);
    win_sig = 1'b1;
    ball_lost = 1'b1;
    step();
    win_sig = 1'b0;
    ball_lost = 1'b0;
    chk("start_ignores_sigs", 8'(game_state), 8'd0);
    key_start = 1'b1;
    repeat (3) step();
    chk("start_k2_state", 8'(game_state), 8'd0);
    step();
    chk("start_k3_state", 8'(game_state), 8'd1);
    chk("start_greset", 8'(game_reset), 8'd1);
    chk("start_serve", 8'(serve), 8'd1);
    chk("start_lives", 8'(lives), L0);
    pulses_r = 0;
    pulses_s = 0;
    repeat (6) begin
      step();
      pulses_r += int'(game_reset);
      pulses_s += int'(serve);
    end
    key_start = 1'b0;
    chk("held_key_greset_extra", 8'(pulses_r), 8'd0);
    chk("held_key_serve_extra", 8'(pulses_s), 8'd0);
    repeat (3) step();
    chk("play_ignores_key", 8'(game_state), 8'd1);
`ifdef LIVES_EN
    ball_lost = 1'b1;
    step();
    ball_lost = 1'b0;
    chk("lost1_lives", 8'(lives), 8'd2);
    chk("lost1_serve", 8'(serve), 8'd1);
    chk("lost1_state", 8'(game_state), 8'd1);
    step();
    chk("lost1_serve_end", 8'(serve), 8'd0);
    ball_lost = 1'b1;
    step();
    ball_lost = 1'b0;
    chk("lost2_lives", 8'(lives), 8'd1);
    chk("lost2_serve", 8'(serve), 8'd1);
    step();
`endif
    ball_lost = 1'b1;
    step();
    ball_lost = 1'b0;
    chk("over_state", 8'(game_state), 8'd3);
    chk("over_lives", 8'(lives), 8'd0);
    chk("over_serve", 8'(serve), 8'd0);
    ticks(4);
    press();
    chk("over_exit_state", 8'(game_state), 8'd0);
    chk("over_exit_greset", 8'(game_reset), 8'd0);
`ifdef LIVES_EN
    chk("over_exit_lives", 8'(lives), 8'd0);
`else
    chk("over_exit_lives", 8'(lives), 8'd1);
`endif
    release_key();
    press();
    chk("restart_state", 8'(game_state), 8'd1);
    chk("restart_greset", 8'(game_reset), 8'd1);
    chk("restart_lives", 8'(lives), L0);
    release_key();
    win_sig = 1'b1;
    ball_lost = 1'b1;
    step();
    win_sig = 1'b0;
    ball_lost = 1'b0;
    chk("win_lost_state", 8'(game_state), 8'd2);
    chk("win_lost_lives", 8'(lives), L0);
    ticks(2);
    press();
    chk("win_early_key", 8'(game_state), 8'd2);
    release_key();
    ticks(2);
    press();
    chk("win_hold_exit", 8'(game_state), 8'd0);
    chk("win_exit_greset", 8'(game_reset), 8'd0);
    release_key();
    press();
    release_key();
`ifdef LIVES_EN
    ball_lost = 1'b1;
    step();
    ball_lost = 1'b0;
    chk("pre_rst_lives", 8'(lives), 8'd2);
`endif
    chk("pre_rst_state", 8'(game_state), 8'd1);
    rst = 1'b1;
    win_sig = 1'b1;
    step();
    rst = 1'b0;
    win_sig = 1'b0;
    chk("mid_rst_state", 8'(game_state), 8'd0);
    chk("mid_rst_lives", 8'(lives), L0);
    chk("mid_rst_greset", 8'(game_reset), 8'd0);
    chk("mid_rst_serve", 8'(serve), 8'd0);
    key_start = 1'b1;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
    chk("rst_held_key_k2", 8'(game_state), 8'd0);
    step();
    chk("rst_held_key_k3", 8'(game_state), 8'd1);
    key_start = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
